big_ram_dma: RTL and testbench

- Word-copy DMA engine that acts as a pipelined Wishbone master directly upstream of big_ram.
- Reads a block of words through one master port and writes them through a second master port. In the SoC these connect to big_ram port A (read) and port B (write).
- A small internal FIFO decouples the two ports, so reads and writes overlap.
- Command interface is a valid/ready handshake from the control CPU; completion is signalled by busy_o and a done_o pulse.

---
 rtl/big_ram_dma_pkg.sv | 13 +
 rtl/big_ram_dma_if.sv | 53 +++++
 rtl/big_ram_dma_fifo.sv | 62 ++++++
 rtl/big_ram_dma.sv | 149 ++++++++++++++
 tb/tb_big_ram_dma.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/big_ram_dma_pkg.sv
// Shared types and defaults for the big_ram word-copy DMA.
// Defaults track the big_ram geometry.
package big_ram_dma_pkg;
   localparam int AW_DEF = 11;
   localparam int DW_DEF = 32;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   typedef logic [AW_DEF:0] len_t;
endpackage

// File: rtl/big_ram_dma_if.sv
// Command handshake plus two pipelined Wishbone master ports (read, write).
// The master modport is the DMA side; the slave modport is the SoC/memory side.
interface big_ram_dma_if
   import big_ram_dma_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
);
   logic          cmd_valid_i;
   logic          cmd_ready_o;
   logic [AW-1:0] cmd_src_i;
   logic [AW-1:0] cmd_dst_i;
   logic [AW:0]   cmd_len_i;
   logic          busy_o;
   logic          done_o;

   logic          rd_wb_cyc_o;
   logic          rd_wb_stb_o;
   logic          rd_wb_we_o;
   logic [AW-1:0] rd_wb_addr_o;
   logic [3:0]    rd_wb_sel_o;
   logic [DW-1:0] rd_wb_data_o;
   logic          rd_wb_ack_i;
   logic          rd_wb_stall_i;
   logic [DW-1:0] rd_wb_data_i;

   logic          wr_wb_cyc_o;
   logic          wr_wb_stb_o;
   logic          wr_wb_we_o;
   logic [AW-1:0] wr_wb_addr_o;
   logic [3:0]    wr_wb_sel_o;
   logic [DW-1:0] wr_wb_data_o;
   logic          wr_wb_ack_i;
   logic          wr_wb_stall_i;

   modport master (
      input  cmd_valid_i, cmd_src_i, cmd_dst_i, cmd_len_i,
      input  rd_wb_ack_i, rd_wb_stall_i, rd_wb_data_i,
      input  wr_wb_ack_i, wr_wb_stall_i,
      output cmd_ready_o, busy_o, done_o,
      output rd_wb_cyc_o, rd_wb_stb_o, rd_wb_we_o, rd_wb_addr_o, rd_wb_sel_o, rd_wb_data_o,
      output wr_wb_cyc_o, wr_wb_stb_o, wr_wb_we_o, wr_wb_addr_o, wr_wb_sel_o, wr_wb_data_o
   );

   modport slave (
      output cmd_valid_i, cmd_src_i, cmd_dst_i, cmd_len_i,
      output rd_wb_ack_i, rd_wb_stall_i, rd_wb_data_i,
      output wr_wb_ack_i, wr_wb_stall_i,
      input  cmd_ready_o, busy_o, done_o,
      input  rd_wb_cyc_o, rd_wb_stb_o, rd_wb_we_o, rd_wb_addr_o, rd_wb_sel_o, rd_wb_data_o,
      input  wr_wb_cyc_o, wr_wb_stb_o, wr_wb_we_o, wr_wb_addr_o, wr_wb_sel_o, wr_wb_data_o
   );
endinterface

// File: rtl/big_ram_dma_fifo.sv
// Synchronous read-data buffer, DW x DEPTH; head is registered (no push-to-head bypass).
// Push when full and pop when empty are ignored.
module big_ram_dma_fifo
   import big_ram_dma_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [DW-1:0]            push_dat_i,
   input  logic                     pop_i,
   output logic [DW-1:0]            head_dat_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   always_comb begin
      do_push  = push_i && (count_q != CW'(DEPTH));
      do_pop   = pop_i && (count_q != '0);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_dat_i;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_dat_o = mem_q[rd_ptr_q];
   assign empty_o    = (count_q == '0);
   assign full_o     = (count_q == CW'(DEPTH));
   assign count_o    = count_q;
endmodule

// File: rtl/big_ram_dma.sv
// Word-copy DMA: pipelined Wishbone reads into a small FIFO, drained by pipelined writes.
// Reads throttle on FIFO occupancy plus reads in flight; first write stb follows the first read ack by >= 1 cycle.
module big_ram_dma
   import big_ram_dma_pkg::*;
#(
   parameter int AW         = AW_DEF,
   parameter int DW         = DW_DEF,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   big_ram_dma_if.master bus
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_e        state_q, state_d;
   logic [AW-1:0] src_q, src_d, dst_q, dst_d;
   logic [AW:0]   rd_left_q, rd_left_d, rd_ack_left_q, rd_ack_left_d;
   logic [AW:0]   wr_left_q, wr_left_d, wr_ack_left_q, wr_ack_left_d;
   logic [CW-1:0] rd_out_q, rd_out_d;
   logic          done_q, done_d;

   logic [CW-1:0] fifo_count;
   logic [DW-1:0] fifo_head;
   logic          fifo_empty, fifo_full;
   logic          rd_stb, rd_req, rd_ack, wr_stb, wr_req, wr_ack, wr_pending;

   always_comb begin
      // Reserve a FIFO slot for every read in flight so an ack always has room.
      rd_stb     = (state_q == RUN) && (rd_left_q != '0) && !fifo_full &&
                   (({1'b0, fifo_count} + {1'b0, rd_out_q}) < (CW+1)'(FIFO_DEPTH));
      rd_req     = rd_stb && !bus.rd_wb_stall_i;
      rd_ack     = bus.rd_wb_ack_i && (rd_out_q != '0);
      wr_stb     = (state_q == RUN) && !fifo_empty && (wr_left_q != '0);
      wr_req     = wr_stb && !bus.wr_wb_stall_i;
      wr_pending = (wr_ack_left_q != wr_left_q);
      wr_ack     = bus.wr_wb_ack_i && wr_pending;
   end

   always_comb begin
      state_d       = state_q;
      src_d         = src_q;
      dst_d         = dst_q;
      rd_left_d     = rd_left_q;
      rd_ack_left_d = rd_ack_left_q;
      wr_left_d     = wr_left_q;
      wr_ack_left_d = wr_ack_left_q;
      rd_out_d      = rd_out_q;
      done_d        = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.cmd_valid_i) begin
               src_d         = bus.cmd_src_i;
               dst_d         = bus.cmd_dst_i;
               rd_left_d     = bus.cmd_len_i;
               rd_ack_left_d = bus.cmd_len_i;
               wr_left_d     = bus.cmd_len_i;
               wr_ack_left_d = bus.cmd_len_i;
               rd_out_d      = '0;
               if (bus.cmd_len_i == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (rd_req) begin
               src_d     = src_q + 1'b1;
               rd_left_d = rd_left_q - 1'b1;
            end
            rd_out_d = rd_out_q + CW'(rd_req) - CW'(rd_ack);
            if (rd_ack) begin
               rd_ack_left_d = rd_ack_left_q - 1'b1;
            end
            if (wr_req) begin
               dst_d     = dst_q + 1'b1;
               wr_left_d = wr_left_q - 1'b1;
            end
            if (wr_ack) begin
               wr_ack_left_d = wr_ack_left_q - 1'b1;
               if (wr_ack_left_q == (AW+1)'(1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         src_q         <= '0;
         dst_q         <= '0;
         rd_left_q     <= '0;
         rd_ack_left_q <= '0;
         wr_left_q     <= '0;
         wr_ack_left_q <= '0;
         rd_out_q      <= '0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         src_q         <= src_d;
         dst_q         <= dst_d;
         rd_left_q     <= rd_left_d;
         rd_ack_left_q <= rd_ack_left_d;
         wr_left_q     <= wr_left_d;
         wr_ack_left_q <= wr_ack_left_d;
         rd_out_q      <= rd_out_d;
         done_q        <= done_d;
      end
   end

   big_ram_dma_fifo #(
      .DW    (DW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .push_i     (rd_ack),
      .push_dat_i (bus.rd_wb_data_i),
      .pop_i      (wr_req),
      .head_dat_o (fifo_head),
      .empty_o    (fifo_empty),
      .full_o     (fifo_full),
      .count_o    (fifo_count)
   );

   assign bus.cmd_ready_o  = (state_q == IDLE);
   assign bus.busy_o       = (state_q == RUN);
   assign bus.done_o       = done_q;

   assign bus.rd_wb_cyc_o  = (rd_ack_left_q != '0);
   assign bus.rd_wb_stb_o  = rd_stb;
   assign bus.rd_wb_we_o   = 1'b0;
   assign bus.rd_wb_addr_o = src_q;
   assign bus.rd_wb_sel_o  = 4'hF;
   assign bus.rd_wb_data_o = '0;

   // Write cycle spans from the first stb until every accepted write is acked.
   assign bus.wr_wb_cyc_o  = wr_stb || wr_pending;
   assign bus.wr_wb_stb_o  = wr_stb;
   assign bus.wr_wb_we_o   = wr_stb;
   assign bus.wr_wb_addr_o = dst_q;
   assign bus.wr_wb_sel_o  = 4'hF;
   assign bus.wr_wb_data_o = fifo_head;
endmodule

// File: tb/tb_big_ram_dma.sv
// Directed bench for big_ram_dma: Wishbone memory model on both ports sharing one array,
// acceptance/in-flight monitor, and hand-computed expected memory contents.
module tb_big_ram_dma;
   import big_ram_dma_pkg::*;

   localparam int AW    = 11;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic clk    = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk = ~clk;

   big_ram_dma_if #(.AW(AW), .DW(DW)) bus ();

   big_ram_dma #(
      .AW         (AW),
      .DW         (DW),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   logic [DW-1:0] mem [0:2047];
   logic          pl_en    = 1'b0;
   logic [AW-1:0] pl_addr  = '0;
   logic [DW-1:0] pl_dat   = '0;
   logic          rnd_en   = 1'b0;
   logic          force_wr = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   // Memory model: accept on cyc&&stb&&!stall, ack the following cycle.
   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_dat;
      if (!rst_ni) begin
         bus.rd_wb_ack_i <= 1'b0;
         bus.wr_wb_ack_i <= 1'b0;
      end else begin
         bus.rd_wb_ack_i <= bus.rd_wb_cyc_o && bus.rd_wb_stb_o && !bus.rd_wb_stall_i;
         if (bus.rd_wb_cyc_o && bus.rd_wb_stb_o && !bus.rd_wb_stall_i)
            bus.rd_wb_data_i <= mem[bus.rd_wb_addr_o];
         bus.wr_wb_ack_i <= bus.wr_wb_cyc_o && bus.wr_wb_stb_o && !bus.wr_wb_stall_i;
         if (bus.wr_wb_cyc_o && bus.wr_wb_stb_o && !bus.wr_wb_stall_i && bus.wr_wb_we_o)
            mem[bus.wr_wb_addr_o] <= bus.wr_wb_data_o;
      end
   end

   always @(posedge clk) begin
      #1;
      bus.rd_wb_stall_i = rnd_en && ($urandom_range(99) < 30);
      bus.wr_wb_stall_i = force_wr || (rnd_en && ($urandom_range(99) < 30));
   end

   logic rd_acc_m, wr_acc_m, rd_ack_m;
   int   rd_acc_cnt = 0, wr_acc_cnt = 0, done_cnt = 0, cyc_cnt = 0, viol_cnt = 0;
   int   m_out = 0, m_fifo = 0;

   assign rd_acc_m = bus.rd_wb_cyc_o && bus.rd_wb_stb_o && !bus.rd_wb_stall_i;
   assign wr_acc_m = bus.wr_wb_cyc_o && bus.wr_wb_stb_o && !bus.wr_wb_stall_i;
   assign rd_ack_m = bus.rd_wb_ack_i && (m_out > 0);

   always @(negedge clk) begin
      if (!rst_ni) begin
         m_out  <= 0;
         m_fifo <= 0;
      end else begin
         if (bus.rd_wb_stb_o && (m_out + m_fifo) >= DEPTH) viol_cnt <= viol_cnt + 1;
         if (rd_acc_m) rd_acc_cnt <= rd_acc_cnt + 1;
         if (wr_acc_m) wr_acc_cnt <= wr_acc_cnt + 1;
         if (bus.done_o) done_cnt <= done_cnt + 1;
         if (bus.rd_wb_cyc_o || bus.wr_wb_cyc_o) cyc_cnt <= cyc_cnt + 1;
         m_out  <= m_out + (rd_acc_m ? 1 : 0) - (rd_ack_m ? 1 : 0);
         m_fifo <= m_fifo + (rd_ack_m ? 1 : 0) - (wr_acc_m ? 1 : 0);
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic poke(input int a, input logic [31:0] d);
      @(negedge clk);
      pl_en   = 1'b1;
      pl_addr = a[AW-1:0];
      pl_dat  = d;
      @(posedge clk);
      #1 pl_en = 1'b0;
   endtask

   // Returns at the first negedge after acceptance; inputs then change to junk.
   task automatic issue(input int s, input int d, input int l);
      @(negedge clk);
      chk("ready_before_cmd", bus.cmd_ready_o, 1'b1);
      bus.cmd_valid_i = 1'b1;
      bus.cmd_src_i   = s[AW-1:0];
      bus.cmd_dst_i   = d[AW-1:0];
      bus.cmd_len_i   = len_t'(l);
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
      bus.cmd_src_i   = 11'h3A5;
      bus.cmd_dst_i   = 11'h15A;
      bus.cmd_len_i   = len_t'(3);
   endtask

   task automatic wait_done(input int budget, output int cyc, output int busy_low);
      cyc      = 0;
      busy_low = 0;
      while (!bus.done_o && cyc < budget) begin
         if (!bus.busy_o) busy_low++;
         @(negedge clk);
         cyc++;
      end
      chk("done_seen", bus.done_o, 1'b1);
      chk("ready_at_done", bus.cmd_ready_o, 1'b1);
      @(negedge clk);
      chk("done_one_cycle", bus.done_o, 1'b0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int c, bl, b_rd, b_wr, b_done, b_cyc, b_viol, n, bad;
      bus.cmd_valid_i = 1'b0;
      bus.cmd_src_i   = '0;
      bus.cmd_dst_i   = '0;
      bus.cmd_len_i   = '0;

      repeat (3) @(negedge clk);
      chk("rst_ready", bus.cmd_ready_o, 1'b1);
      chk("rst_busy", bus.busy_o, 1'b0);
      chk("rst_done", bus.done_o, 1'b0);
      chk("rst_rd_cyc", bus.rd_wb_cyc_o, 1'b0);
      chk("rst_rd_stb", bus.rd_wb_stb_o, 1'b0);
      chk("rst_wr_cyc", bus.wr_wb_cyc_o, 1'b0);
      chk("rst_wr_stb", bus.wr_wb_stb_o, 1'b0);
      chk("rst_wr_we", bus.wr_wb_we_o, 1'b0);
      chk("rst_rd_addr", bus.rd_wb_addr_o, 0);
      chk("rst_wr_addr", bus.wr_wb_addr_o, 0);
      chk("rst_wr_data", bus.wr_wb_data_o, 0);
      chk("rd_sel", bus.rd_wb_sel_o, 4'hF);
      chk("wr_sel", bus.wr_wb_sel_o, 4'hF);
      rst_ni = 1'b1;

      // Basic copy 0..7 -> 256..263.
      for (int i = 0; i < 8; i++) poke(i, 32'h1000_0000 + i);
      for (int i = 0; i < 8; i++) poke(256 + i, 32'h0);
      b_rd = rd_acc_cnt; b_wr = wr_acc_cnt; b_done = done_cnt; b_viol = viol_cnt;
      issue(0, 256, 8);
      wait_done(300, c, bl);
      chk("basic_busy_low", bl, 0);
      for (int i = 0; i < 8; i++)
         chk($sformatf("basic_w%0d", i), mem[256 + i], 32'h1000_0000 + i);
      chk("basic_rd_acc", rd_acc_cnt - b_rd, 8);
      chk("basic_wr_acc", wr_acc_cnt - b_wr, 8);
      chk("basic_done_cnt", done_cnt - b_done, 1);
      chk("basic_viol", viol_cnt - b_viol, 0);

      // Zero length: no bus cycles, done on the first cycle after acceptance.
      poke(9, 32'h0BAD_0009);
      b_cyc = cyc_cnt; b_done = done_cnt;
      issue(5, 9, 0);
      wait_done(20, c, bl);
      chk("len0_latency", c, 0);
      chk("len0_no_cyc", cyc_cnt - b_cyc, 0);
      chk("len0_done_cnt", done_cnt - b_done, 1);
      chk("len0_mem", mem[9], 32'h0BAD_0009);

      // Source wraps 2047 -> 0.
      poke(2046, 32'hDEADBEEF);
      poke(2047, 32'hBEEFCAFE);
      poke(0, 32'hAABBCCDD);
      poke(1, 32'h12345678);
      issue(2046, 100, 4);
      wait_done(200, c, bl);
      chk("wrap_w0", mem[100], 32'hDEADBEEF);
      chk("wrap_w1", mem[101], 32'hBEEFCAFE);
      chk("wrap_w2", mem[102], 32'hAABBCCDD);
      chk("wrap_w3", mem[103], 32'h12345678);

      // Write backpressure: reads stop once DEPTH words are buffered or in flight.
      for (int i = 0; i < 16; i++) poke(300 + i, 32'hB000_0000 + i);
      b_rd = rd_acc_cnt; b_wr = wr_acc_cnt; b_done = done_cnt; b_viol = viol_cnt;
      @(negedge clk);
      force_wr = 1'b1;
      issue(300, 400, 16);
      repeat (15) @(negedge clk);
      chk("bp_rd_inflight", rd_acc_cnt - b_rd, DEPTH);
      chk("bp_no_writes", wr_acc_cnt - b_wr, 0);
      repeat (5) @(negedge clk);
      force_wr = 1'b0;
      wait_done(500, c, bl);
      for (int i = 0; i < 16; i++)
         chk($sformatf("bp_w%0d", i), mem[400 + i], 32'hB000_0000 + i);
      chk("bp_viol", viol_cnt - b_viol, 0);
      chk("bp_done_cnt", done_cnt - b_done, 1);

      // Reset at the 5th write ack abandons the transfer.
      for (int i = 0; i < 32; i++) poke(500 + i, 32'hC000_0000 + i);
      b_done = done_cnt;
      issue(500, 600, 32);
      n = 0; c = 0;
      while (n < 5 && c < 500) begin
         @(negedge clk);
         c++;
         if (bus.wr_wb_ack_i) n++;
      end
      chk("rst_mid_ack5", n, 5);
      rst_ni = 1'b0;
      #1;
      chk("rst_mid_rd_cyc", bus.rd_wb_cyc_o, 1'b0);
      chk("rst_mid_rd_stb", bus.rd_wb_stb_o, 1'b0);
      chk("rst_mid_wr_cyc", bus.wr_wb_cyc_o, 1'b0);
      chk("rst_mid_wr_stb", bus.wr_wb_stb_o, 1'b0);
      chk("rst_mid_busy", bus.busy_o, 1'b0);
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_mid_no_done", done_cnt - b_done, 0);
      for (int i = 0; i < 6; i++) poke(700 + i, 32'hD000_0000 + i);
      b_done = done_cnt;
      issue(700, 800, 6);
      wait_done(300, c, bl);
      for (int i = 0; i < 6; i++)
         chk($sformatf("post_rst_w%0d", i), mem[800 + i], 32'hD000_0000 + i);
      chk("post_rst_done_cnt", done_cnt - b_done, 1);

      // Full-memory in-place copy with random stalls on both ports.
      for (int i = 0; i < 2048; i++) poke(i, 32'(i) * 32'h9E3779B1);
      b_rd = rd_acc_cnt; b_wr = wr_acc_cnt; b_done = done_cnt; b_viol = viol_cnt;
      rnd_en = 1'b1;
      issue(0, 0, 2048);
      wait_done(40000, c, bl);
      rnd_en = 1'b0;
      bad = 0;
      for (int i = 0; i < 2048; i++)
         if (mem[i] !== 32'(i) * 32'h9E3779B1) bad++;
      chk("full_bad_words", bad, 0);
      chk("full_rd_acc", rd_acc_cnt - b_rd, 2048);
      chk("full_wr_acc", wr_acc_cnt - b_wr, 2048);
      chk("full_done_cnt", done_cnt - b_done, 1);
      chk("full_viol", viol_cnt - b_viol, 0);
      chk("full_ready", bus.cmd_ready_o, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
